// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter between the CPU and the UART loader.
package dmem_arb_pkg;

  localparam int DMEM_AW      = 32;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    SHARED = 2'd0,
    LOCKED = 2'd1,
    DRAIN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_rvalid_pipe.sv
// Shift register that tracks outstanding loader reads and emits ldr_rvalid RD_LAT cycles after the grant.
module dmem_rvalid_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push,
  output logic rvalid,
  output logic empty
);

  logic [RD_LAT-1:0] sr;
  logic              busy;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else begin
      sr[0] <= push;
      for (int i = 1; i < RD_LAT; i++) sr[i] <= sr[i-1];
    end
  end

  // The output stage delivers this cycle, so only the earlier stages count as still in flight.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) busy = busy | sr[i];
  end

  assign rvalid = sr[RD_LAT-1];
  assign empty  = ~busy;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the CPU (fixed priority, starvation guard) and the loader,
// with a lock mode that hands the loader exclusive access during boot download.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int RD_LAT     = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [DMEM_AW-1:0] cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic [31:0]        cpu_rdata,
  output logic               cpu_stall,
  input  logic               ldr_lock,
  input  logic               ldr_req,
  input  logic               ldr_we,
  input  logic [DMEM_AW-1:0] ldr_addr,
  input  logic [31:0]        ldr_wdata,
  output logic               ldr_ack,
  output logic [31:0]        ldr_rdata,
  output logic               ldr_rvalid,
  output logic [DMEM_AW-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               mem_we,
  input  logic [31:0]        mem_rdata,
  output logic               locked
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  arb_state_e              state, state_nxt;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    gnt_ldr, gnt_cpu;
  logic                    pipe_rvalid, pipe_empty;

  // DRAIN grants nobody; SHARED lets the loader in when the CPU is idle or has used up its run.
  always_comb begin
    gnt_ldr = ldr_req & ((state == LOCKED) |
              ((state == SHARED) & (~cpu_req | (starve_cnt == STARVE_LIM))));
    gnt_cpu = cpu_req & (state == SHARED) & ~gnt_ldr;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= SHARED;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SHARED:  if (ldr_lock) state_nxt = LOCKED;
      LOCKED:  if (!ldr_lock) state_nxt = DRAIN;
      DRAIN: begin
        if (ldr_lock)        state_nxt = LOCKED;
        else if (pipe_empty) state_nxt = SHARED;
      end
      default: state_nxt = SHARED;
    endcase
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    if (gnt_ldr) begin
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
      mem_we    = ldr_we;
    end else if (gnt_cpu) begin
      mem_we = cpu_we;
    end
    cpu_stall  = cpu_req & ~gnt_cpu;
    ldr_ack    = gnt_ldr;
    ldr_rvalid = pipe_rvalid;
    locked     = (state != SHARED);
    // Hold every control/address output quiet while reset is asserted.
    if (!reset_n) begin
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_we     = 1'b0;
      cpu_stall  = 1'b0;
      ldr_ack    = 1'b0;
      ldr_rvalid = 1'b0;
      locked     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (gnt_ldr || !ldr_req) begin
      starve_cnt <= '0;
    end else if (gnt_cpu && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign cpu_rdata = mem_rdata;
  assign ldr_rdata = mem_rdata;

  dmem_rvalid_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rvalid_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (gnt_ldr & ~ldr_we),
    .rvalid  (pipe_rvalid),
    .empty   (pipe_empty)
  );

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM (dmemory32) between the CPU data path and the UART program/data loader (DMA-style requester).
- Sits between the execution unit/loader and dmemory32, driving its address, write_data and Memwrite and steering read_data back.
- Fixed CPU priority with a starvation guard, plus a lock mode that gives the loader exclusive access during boot download.

Parameters:
- STARVE_MAX, 4, max consecutive CPU grants while ldr_req is pending before the loader is forced one slot (range 1..15).
- RD_LAT, 1, cycles from grant to valid mem_rdata (range 1..2).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU memory access this cycle (load or store)
- cpu_we  in  1  CPU store
- cpu_addr  in  32  byte address (ALU result)
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data (mem_rdata passthrough)
- cpu_stall  out  1  CPU must hold its request and freeze the PC
- ldr_lock  in  1  request exclusive loader mode
- ldr_req  in  1  loader access request; held until acked
- ldr_we  in  1  loader write
- ldr_addr  in  32  byte address
- ldr_wdata  in  32  write data
- ldr_ack  out  1  one-cycle grant pulse to the loader
- ldr_rdata  out  32  loader read data
- ldr_rvalid  out  1  ldr_rdata valid, one-cycle pulse
- mem_addr  out  32  to dmemory32 address
- mem_wdata  out  32  to dmemory32 write_data
- mem_we  out  1  to dmemory32 Memwrite
- mem_rdata  in  32  from dmemory32 read_data
- locked  out  1  arbiter in LOCKED state

Behaviour:
- Reset (async, reset_n=0):
  - State SHARED; starve_cnt=0; rvalid pipeline cleared.
  - All outputs 0 except cpu_rdata and ldr_rdata, which follow mem_rdata.
- Grant (combinational each cycle):
  - gnt_ldr = ldr_req and (state==LOCKED, or !cpu_req, or starve_cnt==STARVE_MAX).
  - gnt_cpu = cpu_req and state==SHARED and !gnt_ldr.
- Memory mux: mem_addr/mem_wdata/mem_we come from the granted requester. mem_we = granted_we. With no grant, mem_we=0 and addr/wdata hold the CPU values.
- cpu_stall = cpu_req and !gnt_cpu.
- ldr_ack = gnt_ldr. The loader must keep req/addr/we/wdata stable until ack and may issue a new request in the cycle after ack.
- Loader reads:
  - ldr_rvalid asserts exactly RD_LAT cycles after an ack with ldr_we=0, via a shift register.
  - ldr_rdata = mem_rdata.
  - Back-to-back loader reads give back-to-back rvalid.
- CPU reads: cpu_rdata = mem_rdata. The CPU consumes it on the timing it already uses with dmemory32. The arbiter adds no CPU latency when the CPU is granted.
- starve_cnt (4-bit):
  - Increments on gnt_cpu while ldr_req=1.
  - Clears on gnt_ldr or when ldr_req=0.
  - Saturates at STARVE_MAX.
- FSM:
  - SHARED -> LOCKED when ldr_lock=1. The CPU is granted normally in that same cycle; arbitration changes from the next cycle.
  - LOCKED: the CPU is always stalled and the loader is granted whenever ldr_req=1. Exit to DRAIN when ldr_lock=0.
  - DRAIN: no new grants to either side. Go to SHARED when the rvalid pipeline is empty; this takes at most RD_LAT cycles.
  - DRAIN -> LOCKED if ldr_lock re-asserts.
- locked = (state != SHARED).
- Simultaneous events:
  - cpu_req and ldr_req in the same cycle in SHARED with starve_cnt<STARVE_MAX: the CPU wins.
  - ldr_lock rising with ldr_req in the same cycle: the SHARED rules apply for that cycle.
- Reset mid-operation: pending rvalid is dropped, with no spurious pulse after reset release. The loader must re-issue.
- Address bits are passed unmodified; word alignment is the consumer's concern.

Decomposition:
- Shared package dmem_arb_pkg:
  - State enum {SHARED, LOCKED, DRAIN}, 2 bits.
  - Constant DMEM_AW=32.
  - STARVE_CNT_W=4.
- One natural sub-module: dmem_rvalid_pipe, a RD_LAT-deep shift register producing ldr_rvalid and a pipeline-empty flag.

Test Plan:
- Reset then CPU-only traffic: cpu_req=1, cpu_we=1, addr 0x10, data 0xDEADBEEF.
  - Expect mem_we=1, mem_addr=0x10, cpu_stall=0.
  - A read of 0x10 returns 0xDEADBEEF on cpu_rdata.
- Idle CPU with loader write to 0x20 of 0x12345678: ldr_ack the same cycle; a later loader read gives ldr_rvalid RD_LAT cycles after ack, ldr_rdata=0x12345678.
- Starvation: cpu_req held 1 and ldr_req held 1, STARVE_MAX=4.
  - Expect 4 CPU grants, then 1 ldr_ack with cpu_stall=1 for that cycle.
  - The pattern repeats every 5 cycles.
- Lock: assert ldr_lock while the CPU loops.
  - From the next cycle, cpu_stall=1 continuously and locked=1.
  - 8 loader writes at 0x0..0x1C are acked.
  - Deassert with a read outstanding: DRAIN, rvalid still delivered, then SHARED and the CPU resumes.
- Async reset asserted mid loader read (before rvalid): all outputs 0 immediately, no ldr_rvalid after release, state SHARED.
- Simultaneous cpu_req and ldr_req with starve_cnt=0: CPU granted, ldr_ack=0, starve_cnt becomes 1.
